// File: rtl/wshb_ram_slave_if.sv
// Wishbone B4 bus bundle between an initiator and the RAM slave.
// Clock and reset travel with the bus so the slave sees a single port.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, rst, dat_sm, ack, err, rty,
        output cyc, stb, we, adr, sel, dat_ms, cti, bte
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 registered-feedback RAM slave: classic cycles plus linear and
// wrapping incrementing bursts, with err on out-of-range first addresses.
module wshb_ram_slave #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    wshb_if.slave wshb_ifs
);

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] badr, badr_nxt;
    logic [AW-1:0] req_idx, rd_idx, adv_idx;
    logic [1:0]    bte_q;
    logic          ack_q, err_q, ack_d, err_d;
    logic [31:0]   dat_q;
    logic          req, oor, beat, last, latch;
    logic          unused_adr;

    logic [31:0] mem [DEPTH];

    // Next word index within a burst; wrap modes keep the upper bits fixed.
    function automatic logic [AW-1:0] next_badr(input logic [AW-1:0] a,
                                                input logic [1:0]    mode);
        logic [AW-1:0] m;
        logic [AW-1:0] inc;
        inc = a + AW'(1);
        case (mode)
            2'b01:   m = AW'(3);
            2'b10:   m = AW'(7);
            2'b11:   m = AW'(15);
            default: m = '1;
        endcase
        return (a & ~m) | (inc & m);
    endfunction

    assign req        = wshb_ifs.cyc & wshb_ifs.stb & ~ack_q & ~err_q;
    assign req_idx    = wshb_ifs.adr[AW+1:2];
    assign oor        = |wshb_ifs.adr[31:AW+2];
    assign beat       = wshb_ifs.cyc & wshb_ifs.stb & ack_q;
    assign last       = (wshb_ifs.cti == 3'b111);
    assign adv_idx    = next_badr(badr, bte_q);
    assign unused_adr = ^wshb_ifs.adr[1:0];

    // State and registered bus outputs
    always_ff @(posedge wshb_ifs.clk) begin
        if (wshb_ifs.rst) begin
            state <= IDLE;
            badr  <= '0;
            bte_q <= 2'b00;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            state <= state_nxt;
            badr  <= badr_nxt;
            ack_q <= ack_d;
            err_q <= err_d;
            if (latch) bte_q <= wshb_ifs.bte;
            if (ack_d) dat_q <= mem[rd_idx];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (oor)                            state_nxt = ERR;
                    else if (wshb_ifs.cti == 3'b010)    state_nxt = BURST;
                    else                                state_nxt = SINGLE;
                end
            end
            SINGLE: state_nxt = IDLE;
            BURST: begin
                if (!(wshb_ifs.cyc && wshb_ifs.stb) || last) state_nxt = IDLE;
            end
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The read port fetches the word that will be on dat_sm next cycle.
    always_comb begin
        ack_d    = (state_nxt == SINGLE) || (state_nxt == BURST);
        err_d    = (state_nxt == ERR);
        latch    = (state == IDLE) && req;
        badr_nxt = badr;
        rd_idx   = adv_idx;
        if (state == IDLE) rd_idx = req_idx;
        if (latch)
            badr_nxt = req_idx;
        else if (state == BURST && beat)
            badr_nxt = adv_idx;
    end

    always_ff @(posedge wshb_ifs.clk) begin
        if (!wshb_ifs.rst && beat && wshb_ifs.we) begin
            for (int i = 0; i < 4; i++) begin
                if (wshb_ifs.sel[i]) mem[badr][8*i +: 8] <= wshb_ifs.dat_ms[8*i +: 8];
            end
        end
    end

    assign wshb_ifs.ack    = ack_q;
    assign wshb_ifs.err    = err_q;
    assign wshb_ifs.dat_sm = dat_q;
    assign wshb_ifs.rty    = 1'b0;

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Directed bench for wshb_ram_slave: table of classic cycles plus hand-written
// burst, wrap, abort and reset sequences.
module tb_wshb_ram_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    wshb_if bus (.clk(clk), .rst(rst));
    wshb_ram_slave #(.DEPTH(4096)) dut (.wshb_ifs(bus));

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0;
        bus.sel = 4'h0; bus.dat_ms = '0; bus.cti = 3'b000; bus.bte = 2'b00;
    endtask

    task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_dat,
                           input string name);
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we; bus.adr = adr;
        bus.dat_ms = dat; bus.sel = sel; bus.cti = 3'b000; bus.bte = 2'b00;
        @(posedge clk); #1;
        check({name, " ack"}, 32'(bus.ack), 32'(!exp_err));
        check({name, " err"}, 32'(bus.err), 32'(exp_err));
        if (!we && !exp_err) check({name, " dat"}, bus.dat_sm, exp_dat);
        @(posedge clk); #1;
        idle_bus();
        check({name, " ack drop"}, 32'({bus.ack, bus.err}), 32'(0));
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        classic(1'b1, adr, dat, 4'hF, 1'b0, '0, "preload");
    endtask

    logic [31:0] wdat[4];

    initial begin
        idle_bus();
        vecs[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,        32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h20,        32'h11223344, 4'hF, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 32'h20,        32'hAABBCCDD, 4'h5, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h20,        32'h0,        4'hF, 1'b0, 32'h11BB33DD};
        vecs[5]  = '{1'b0, 32'h4000,      32'h0,        4'hF, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h10,        32'h0,        4'hF, 1'b0, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 32'h3FFC,      32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h3FFC,      32'h0,        4'hF, 1'b0, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 32'h4010,      32'h12345678, 4'hF, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 32'hFFFFFFF0,  32'h87654321, 4'hF, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 32'h10,        32'h0,        4'hF, 1'b0, 32'hDEADBEEF};

        repeat (3) @(posedge clk);
        #1;
        check("reset ack", 32'(bus.ack), 32'(0));
        check("reset err", 32'(bus.err), 32'(0));
        check("reset rty", 32'(bus.rty), 32'(0));
        check("reset dat_sm", bus.dat_sm, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            classic(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                    vecs[i].exp_err, vecs[i].exp_dat, $sformatf("vec%0d", i));

        // Linear read burst over words 0..3
        for (int i = 0; i < 4; i++) wr(32'(i * 4), 32'(i));
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h0;
        bus.cti = 3'b010; bus.bte = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("lin beat%0d ack", i), 32'(bus.ack), 32'(1));
            check($sformatf("lin beat%0d dat", i), bus.dat_sm, 32'(i));
            bus.adr = 32'h100;
            if (i == 3) bus.cti = 3'b111;
        end
        @(posedge clk); #1;
        check("lin end ack", 32'(bus.ack), 32'(0));
        idle_bus();

        // Wrap-4 write burst from word 6
        wdat[0] = 32'hAAAA0001; wdat[1] = 32'hBBBB0002;
        wdat[2] = 32'hCCCC0003; wdat[3] = 32'hDDDD0004;
        wr(32'h20, 32'h88888888);
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h18;
        bus.sel = 4'hF; bus.cti = 3'b010; bus.bte = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("wrap beat%0d ack", i), 32'(bus.ack), 32'(1));
            bus.dat_ms = wdat[i];
            bus.bte = 2'b00;
            if (i == 3) bus.cti = 3'b111;
        end
        @(posedge clk); #1;
        check("wrap end ack", 32'(bus.ack), 32'(0));
        idle_bus();
        classic(1'b0, 32'h18, '0, 4'hF, 1'b0, wdat[0], "wrap w6");
        classic(1'b0, 32'h1C, '0, 4'hF, 1'b0, wdat[1], "wrap w7");
        classic(1'b0, 32'h10, '0, 4'hF, 1'b0, wdat[2], "wrap w4");
        classic(1'b0, 32'h14, '0, 4'hF, 1'b0, wdat[3], "wrap w5");
        classic(1'b0, 32'h20, '0, 4'hF, 1'b0, 32'h88888888, "wrap w8");

        // Abort a 4-beat linear write burst after 2 beats
        for (int i = 16; i < 20; i++) wr(32'(i * 4), 32'h0);
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = 32'h40;
        bus.sel = 4'hF; bus.cti = 3'b010; bus.bte = 2'b00;
        @(posedge clk); #1;
        bus.dat_ms = 32'hE0E0E0E0;
        @(posedge clk); #1;
        bus.dat_ms = 32'hE1E1E1E1;
        @(posedge clk); #1;
        bus.stb = 1'b0; bus.dat_ms = 32'hE2E2E2E2;
        @(posedge clk); #1;
        check("abort ack", 32'(bus.ack), 32'(0));
        idle_bus();
        classic(1'b0, 32'h40, '0, 4'hF, 1'b0, 32'hE0E0E0E0, "abort w16");
        classic(1'b0, 32'h44, '0, 4'hF, 1'b0, 32'hE1E1E1E1, "abort w17");
        classic(1'b0, 32'h48, '0, 4'hF, 1'b0, 32'h0, "abort w18");
        classic(1'b0, 32'h4C, '0, 4'hF, 1'b0, 32'h0, "abort w19");

        // Reset in the middle of a read burst
        @(posedge clk); #1;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h18;
        bus.cti = 3'b010; bus.bte = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-rst dat", bus.dat_sm, wdat[1]);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst ack", 32'(bus.ack), 32'(0));
        check("rst err", 32'(bus.err), 32'(0));
        check("rst dat_sm", bus.dat_sm, 32'h0);
        rst = 1'b0;
        idle_bus();
        classic(1'b0, 32'h3FFC, '0, 4'hF, 1'b0, 32'hCAFEF00D, "post-rst read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
